// File: rtl/ecc_pkg.sv
// Shared SECDED helpers and self-test FSM encoding for the lockstep ECC checker.
package ecc_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INJ  = 2'd1;
   localparam logic [1:0] ST_CHK  = 2'd2;

   // Hamming check bits plus one overall parity bit for a dw-bit word.
   function automatic int unsigned secded_pw(input int unsigned dw);
      int unsigned r;
      r = 1;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((32'd1 << r) < (dw + r + 1)) r = r + 1;
      end
      return r + 1;
   endfunction

   // Codeword position (1-based) of data bit idx; powers of two hold check bits.
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned p;
      p = 3;
      for (int unsigned k = 0; k < idx; k++) begin
         p = p + 1;
         if ((p & (p - 1)) == 0) p = p + 1;
      end
      return p;
   endfunction

endpackage

// File: rtl/ecc_lockstep_chk_secded_cal.sv
// Combinational SECDED decoder: syndrome, overall parity, single-bit correction mask.
module ecc_secded_cal
   import ecc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 22,
   parameter int unsigned PARITY_WIDTH = 6
) (
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   input  logic                    bypass,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [DATA_WIDTH-1:0]   mask,
   output logic                    sbit_err,
   output logic                    dbit_err
);

   localparam int unsigned SW = PARITY_WIDTH - 1;

   logic [DATA_WIDTH-1:0][SW-1:0] pos;
   logic [SW-1:0]                 syn;
   logic                          ovr;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pos
      assign pos[i] = SW'(data_pos(i));
   end

   always_comb begin
      syn = parity_in[SW-1:0];
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (data_in[i]) syn = syn ^ pos[i];
      end
      ovr      = ^{data_in, parity_in};
      sbit_err = ~bypass & ovr;
      dbit_err = ~bypass & ~ovr & (|syn);
      mask     = '0;
      // Syndrome naming a check-bit position leaves the data untouched.
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         mask[i] = sbit_err & (syn == pos[i]);
      end
      data_out = data_in ^ mask;
   end

endmodule

// File: rtl/ecc_lockstep_chk.sv
// Registered SECDED check stage with two lockstep decoders, event counters and comparator self-test.
module ecc_lockstep_chk
   import ecc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 22,
   parameter int unsigned PARITY_WIDTH = 6,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [PARITY_WIDTH-1:0] parity_in,
   input  logic                    bypass,
   input  logic                    detc_en,
   input  logic                    clr_cnt,
   input  logic                    clr_sticky,
   input  logic                    selftest_req,
   output logic                    out_valid,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    sbit_err,
   output logic                    dbit_err,
   output logic                    ecc_fault,
   output logic                    fault_sticky,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   output logic                    selftest_busy,
   output logic                    selftest_done,
   output logic                    selftest_pass
);

   logic [DATA_WIDTH-1:0] data0, data1_unused, mask0, mask1, mask1_inj;
   logic                  sbit0, dbit0, sbit1, dbit1;
   logic                  inj, cmp_eq;

   ecc_secded_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u0 (
      .data_in(data_in), .parity_in(parity_in), .bypass(bypass),
      .data_out(data0), .mask(mask0), .sbit_err(sbit0), .dbit_err(dbit0));

   ecc_secded_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u1 (
      .data_in(data_in), .parity_in(parity_in), .bypass(bypass),
      .data_out(data1_unused), .mask(mask1), .sbit_err(sbit1), .dbit_err(dbit1));

   logic [1:0]            state_q, state_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  sbit_q, sbit_d, dbit_q, dbit_d, fault_q, fault_d;
   logic                  sticky_q, sticky_d;
   logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d, fault_cnt_q, fault_cnt_d;
   logic                  miscmp_q, miscmp_d, done_q, done_d, pass_q, pass_d;

   // Self-test corrupts copy 1 on the injected beat so the comparator must trip.
   assign inj       = (state_q == ST_INJ) & in_valid;
   assign mask1_inj = mask1 ^ DATA_WIDTH'(inj);
   assign cmp_eq    = ({sbit0, dbit0, mask0} == {sbit1, dbit1, mask1_inj});

   always_comb begin
      state_d     = state_q;
      out_valid_d = in_valid;
      data_out_d  = data_out_q;
      sbit_d      = 1'b0;
      dbit_d      = 1'b0;
      fault_d     = 1'b0;
      sticky_d    = sticky_q;
      sbit_cnt_d  = sbit_cnt_q;
      dbit_cnt_d  = dbit_cnt_q;
      fault_cnt_d = fault_cnt_q;
      miscmp_d    = miscmp_q;
      done_d      = 1'b0;
      pass_d      = pass_q;

      if (in_valid) begin
         fault_d    = ~cmp_eq & detc_en & ~inj;
         data_out_d = fault_d ? data_in : data0;
         sbit_d     = sbit0;
         dbit_d     = dbit0;
      end

      if (fault_d)         sticky_d = 1'b1;
      else if (clr_sticky) sticky_d = 1'b0;

      if (clr_cnt) begin
         sbit_cnt_d  = '0;
         dbit_cnt_d  = '0;
         fault_cnt_d = '0;
      end else begin
         if (sbit_d  && (sbit_cnt_q  != '1)) sbit_cnt_d  = sbit_cnt_q  + CNT_WIDTH'(1);
         if (dbit_d  && (dbit_cnt_q  != '1)) dbit_cnt_d  = dbit_cnt_q  + CNT_WIDTH'(1);
         if (fault_d && (fault_cnt_q != '1)) fault_cnt_d = fault_cnt_q + CNT_WIDTH'(1);
      end

      case (state_q)
         ST_IDLE: if (selftest_req) begin
            state_d = ST_INJ;
            pass_d  = 1'b0;
         end
         ST_INJ: if (in_valid) begin
            state_d  = ST_CHK;
            miscmp_d = ~cmp_eq;
         end
         ST_CHK: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            pass_d  = miscmp_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         sbit_q      <= 1'b0;
         dbit_q      <= 1'b0;
         fault_q     <= 1'b0;
         sticky_q    <= 1'b0;
         sbit_cnt_q  <= '0;
         dbit_cnt_q  <= '0;
         fault_cnt_q <= '0;
         miscmp_q    <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         sbit_q      <= sbit_d;
         dbit_q      <= dbit_d;
         fault_q     <= fault_d;
         sticky_q    <= sticky_d;
         sbit_cnt_q  <= sbit_cnt_d;
         dbit_cnt_q  <= dbit_cnt_d;
         fault_cnt_q <= fault_cnt_d;
         miscmp_q    <= miscmp_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign data_out      = data_out_q;
   assign sbit_err      = sbit_q;
   assign dbit_err      = dbit_q;
   assign ecc_fault     = fault_q;
   assign fault_sticky  = sticky_q;
   assign sbit_cnt      = sbit_cnt_q;
   assign dbit_cnt      = dbit_cnt_q;
   assign fault_cnt     = fault_cnt_q;
   assign selftest_busy = (state_q != ST_IDLE);
   assign selftest_done = done_q;
   assign selftest_pass = pass_q;

endmodule
